// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared codes and types for the data-memory arbiter
package dm_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic {
    ARB_ARB  = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Requester that owns a granted access
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // DMType codes understood by dm (sub-word merge happens there)
  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  // One granted access as captured into the issue slot
  typedef struct packed {
    owner_e      owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dtype;
  } dm_req_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - CPU, DMA and dm signal bundle around the arbiter
interface dm_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_type;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [2:0]  dma_type;
  logic        dma_lock;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  dm_type;
  logic [31:0] dm_dout;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_type, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output dm_we, dm_addr, dm_din, dm_type,
    input  dm_dout
  );

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_type, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  dm_we, dm_addr, dm_din, dm_type,
    output dm_dout
  );

endinterface

// File: rtl/dm_issue_slot.sv
// rtl/dm_issue_slot.sv - registered issue slot driving dm plus owner-tagged response demux
module dm_issue_slot
  import dm_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_load,
  input  dm_req_t     i_req,
  input  logic [31:0] i_dm_dout,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_din,
  output logic [2:0]  o_dm_type,
  output logic        o_cpu_rvalid,
  output logic [31:0] o_cpu_rdata,
  output logic        o_dma_rvalid,
  output logic [31:0] o_dma_rdata
);

  dm_req_t r_slot;
  logic    r_valid;
  logic    w_live;
  logic    w_load_rsp;

  // Capture a granted access; fields hold their last value while the slot is empty
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_slot  <= '0;
    end else begin
      r_valid <= i_load;
      if (i_load) r_slot <= i_req;
    end
  end

  // Reset low kills an in-flight slot at once so a pending store never commits
  assign w_live     = r_valid & rstn;
  assign w_load_rsp = w_live & ~r_slot.we;

  // Drive dm from the slot and route load data only to the owner
  always_comb begin
    o_dm_we      = w_live & r_slot.we;
    o_dm_addr    = rstn ? r_slot.addr  : 32'd0;
    o_dm_din     = rstn ? r_slot.wdata : 32'd0;
    o_dm_type    = rstn ? r_slot.dtype : 3'd0;
    o_cpu_rvalid = 1'b0;
    o_cpu_rdata  = 32'd0;
    o_dma_rvalid = 1'b0;
    o_dma_rdata  = 32'd0;
    if (w_load_rsp) begin
      if (r_slot.owner == OWN_CPU) begin
        o_cpu_rvalid = 1'b1;
        o_cpu_rdata  = i_dm_dout;
      end else begin
        o_dma_rvalid = 1'b1;
        o_dma_rdata  = i_dm_dout;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin CPU/DMA arbiter for the data memory with burst lock and CPU timeout
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input logic          clk,
  input logic          rstn,
  dm_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(MAX_WAIT);

  arb_state_e       r_state;
  arb_state_e       w_next;
  owner_e           r_last_gnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_cpu_gnt;
  logic             w_dma_gnt;
  dm_req_t          w_req;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ARB_ARB;
    else       r_state <= w_next;
  end

  // Grant decision and next state; grants are suppressed while in reset
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    w_next    = r_state;
    case (r_state)
      ARB_ARB: begin
        if (bus.cpu_req && bus.dma_req) begin
          if (r_last_gnt == OWN_DMA) w_cpu_gnt = 1'b1;
          else                       w_dma_gnt = 1'b1;
        end else begin
          w_cpu_gnt = bus.cpu_req;
          w_dma_gnt = bus.dma_req;
        end
        if (w_dma_gnt && bus.dma_lock) w_next = ARB_LOCK;
      end
      ARB_LOCK: begin
        // Starved CPU gets one slot without breaking the burst
        if (r_wait_cnt == W_MAX && bus.cpu_req) w_cpu_gnt = 1'b1;
        else                                     w_dma_gnt = bus.dma_req;
        if (!bus.dma_lock || !bus.dma_req) w_next = ARB_ARB;
      end
      default: w_next = ARB_ARB;
    endcase
    if (!rstn) begin
      w_cpu_gnt = 1'b0;
      w_dma_gnt = 1'b0;
    end
  end

  // Round-robin pointer and CPU wait counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_gnt <= OWN_DMA;
      r_wait_cnt <= '0;
    end else begin
      if (w_cpu_gnt)      r_last_gnt <= OWN_CPU;
      else if (w_dma_gnt) r_last_gnt <= OWN_DMA;

      if (r_state == ARB_ARB || w_cpu_gnt)     r_wait_cnt <= '0;
      else if (bus.cpu_req && r_wait_cnt != W_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Select the granted requester's access fields
  always_comb begin
    if (w_dma_gnt) begin
      w_req.owner = OWN_DMA;
      w_req.we    = bus.dma_we;
      w_req.addr  = bus.dma_addr;
      w_req.wdata = bus.dma_wdata;
      w_req.dtype = bus.dma_type;
    end else begin
      w_req.owner = OWN_CPU;
      w_req.we    = bus.cpu_we;
      w_req.addr  = bus.cpu_addr;
      w_req.wdata = bus.cpu_wdata;
      w_req.dtype = bus.cpu_type;
    end
  end

  assign bus.cpu_gnt = w_cpu_gnt;
  assign bus.dma_gnt = w_dma_gnt;

  dm_issue_slot u_slot (
    .clk          (clk),
    .rstn         (rstn),
    .i_load       (w_cpu_gnt | w_dma_gnt),
    .i_req        (w_req),
    .i_dm_dout    (bus.dm_dout),
    .o_dm_we      (bus.dm_we),
    .o_dm_addr    (bus.dm_addr),
    .o_dm_din     (bus.dm_din),
    .o_dm_type    (bus.dm_type),
    .o_cpu_rvalid (bus.cpu_rvalid),
    .o_cpu_rdata  (bus.cpu_rdata),
    .o_dma_rvalid (bus.dma_rvalid),
    .o_dma_rdata  (bus.dma_rdata)
  );

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  logic [31:0] mem [0:63];

  dm_arbiter_if bus ();

  dm_arbiter #(.MAX_WAIT(8), .CNT_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory behind the arbiter: combinational read, byte-lane merge on store
  assign bus.dm_dout = mem[bus.dm_addr[7:2]];

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    forever begin
      @(posedge clk);
      if (bus.dm_we) begin
        w = mem[bus.dm_addr[7:2]];
        case (bus.dm_type)
          3'b001, 3'b010: begin
            if (bus.dm_addr[1]) w[31:16] = bus.dm_din[15:0];
            else                w[15:0]  = bus.dm_din[15:0];
          end
          3'b011, 3'b100: w[{bus.dm_addr[1:0], 3'b000} +: 8] = bus.dm_din[7:0];
          default: w = bus.dm_din;
        endcase
        mem[bus.dm_addr[7:2]] = w;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd0;
    bus.cpu_wdata = 32'd0; bus.cpu_type = dm_word;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 32'd0;
    bus.dma_wdata = 32'd0; bus.dma_type = dm_word; bus.dma_lock = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_inputs();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h20;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid, bus.dm_we} !== 5'b0) begin
        failures++;
        $display("FAIL reset_ctrl cycle=%0d got=%b exp=00000", k,
                 {bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid, bus.dm_we});
      end
      checks++;
      if ((bus.dm_addr | bus.dm_din | bus.cpu_rdata | bus.dma_rdata) !== 32'd0) begin
        failures++;
        $display("FAIL reset_data cycle=%0d addr=%h din=%h crd=%h drd=%h exp=0", k,
                 bus.dm_addr, bus.dm_din, bus.cpu_rdata, bus.dma_rdata);
      end
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_gnt cpu=%b dma=%b exp cpu=1 dma=0", bus.cpu_gnt, bus.dma_gnt);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_tie();
    logic exp_c;
    logic exp_cv;
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h04;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h08;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_c = (k % 2 == 0);
      checks++;
      if (bus.cpu_gnt !== exp_c || bus.dma_gnt !== !exp_c) begin
        failures++;
        $display("FAIL tie_gnt cycle=%0d cpu=%b dma=%b exp cpu=%b dma=%b",
                 k, bus.cpu_gnt, bus.dma_gnt, exp_c, !exp_c);
      end
      if (k > 0) begin
        exp_cv = !exp_c;
        checks++;
        if (bus.cpu_rvalid !== exp_cv || bus.dma_rvalid !== !exp_cv) begin
          failures++;
          $display("FAIL tie_rvalid cycle=%0d cpu=%b dma=%b exp cpu=%b dma=%b",
                   k, bus.cpu_rvalid, bus.dma_rvalid, exp_cv, !exp_cv);
        end
        checks++;
        if (bus.cpu_rdata !== (exp_cv ? 32'hA000_0001 : 32'd0) ||
            bus.dma_rdata !== (exp_cv ? 32'd0 : 32'hA000_0002)) begin
          failures++;
          $display("FAIL tie_rdata cycle=%0d cpu=%h dma=%h exp cpu=%h dma=%h", k,
                   bus.cpu_rdata, bus.dma_rdata, exp_cv ? 32'hA000_0001 : 32'd0,
                   exp_cv ? 32'd0 : 32'hA000_0002);
        end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_raw();
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40;
    bus.cpu_wdata = 32'h1234_5678; bus.cpu_type = dm_word;
    @(negedge clk);
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL raw_store_gnt got=%b exp=1", bus.cpu_gnt);
    end
    @(posedge clk); #1;
    bus.cpu_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dm_we !== 1'b1 || bus.dm_addr !== 32'h40 || bus.dm_din !== 32'h1234_5678 ||
        bus.cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL raw_store_issue we=%b addr=%h din=%h gnt=%b exp we=1 addr=40 din=12345678 gnt=1",
               bus.dm_we, bus.dm_addr, bus.dm_din, bus.cpu_gnt);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h1234_5678 || bus.dm_we !== 1'b0 ||
        bus.dma_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL raw_load rvalid=%b rdata=%h dm_we=%b dma_rv=%b exp 1 12345678 0 0",
               bus.cpu_rvalid, bus.cpu_rdata, bus.dm_we, bus.dma_rvalid);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_byte_store();
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h43;
    bus.cpu_wdata = 32'h0000_00AB; bus.cpu_type = dm_byte;
    @(negedge clk);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dm_we !== 1'b1 || bus.dm_addr !== 32'h43 || bus.dm_type !== dm_byte ||
        bus.cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL byte_issue we=%b addr=%h type=%0d rv=%b exp 1 43 3 0",
               bus.dm_we, bus.dm_addr, bus.dm_type, bus.cpu_rvalid);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40; bus.cpu_type = dm_word;
    @(negedge clk);
    checks++;
    if (bus.dm_we !== 1'b0 || bus.dm_addr !== 32'h43 || bus.cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL byte_idle_hold we=%b addr=%h gnt=%b exp 0 43 1",
               bus.dm_we, bus.dm_addr, bus.cpu_gnt);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hAB34_5678) begin
      failures++;
      $display("FAIL byte_readback rv=%b rdata=%h exp 1 ab345678", bus.cpu_rvalid, bus.cpu_rdata);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_lock_starvation();
    int          dma_cnt;
    int          cpu_cnt;
    int          cpu_cyc;
    int          last_dma;
    int          gap_bad;
    logic        both;
    logic        rv10;
    logic [31:0] rd10;
    do_reset();
    bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 32'h08;
    bus.cpu_addr = 32'h04;
    dma_cnt = 0; cpu_cnt = 0; cpu_cyc = -1; last_dma = -1; gap_bad = 0;
    both = 1'b0; rv10 = 1'b0; rd10 = 32'd0;
    for (int c = 0; c < 60 && dma_cnt < 20; c++) begin
      @(negedge clk);
      if (bus.cpu_gnt && bus.dma_gnt) both = 1'b1;
      if (bus.cpu_gnt) begin
        cpu_cnt++;
        if (cpu_cyc < 0) cpu_cyc = c;
      end
      if (bus.dma_gnt) begin
        dma_cnt++;
        last_dma = c;
      end else if (c != 9) begin
        gap_bad++;
      end
      if (c == 10) begin
        rv10 = bus.cpu_rvalid;
        rd10 = bus.cpu_rdata;
      end
      @(posedge clk); #1;
      bus.cpu_req = (cpu_cnt == 0);
    end
    clear_inputs();
    checks++;
    if (cpu_cyc != 9 || cpu_cnt != 1) begin
      failures++;
      $display("FAIL lock_forced_cpu cycle=%0d count=%0d exp cycle=9 count=1", cpu_cyc, cpu_cnt);
    end
    checks++;
    if (dma_cnt != 20 || last_dma != 20) begin
      failures++;
      $display("FAIL lock_dma_count count=%0d last=%0d exp count=20 last=20", dma_cnt, last_dma);
    end
    checks++;
    if (gap_bad != 0 || both !== 1'b0) begin
      failures++;
      $display("FAIL lock_persist gaps=%0d both=%b exp gaps=0 both=0", gap_bad, both);
    end
    checks++;
    if (rv10 !== 1'b1 || rd10 !== 32'hA000_0001) begin
      failures++;
      $display("FAIL lock_cpu_rsp rv=%b rdata=%h exp 1 a0000001", rv10, rd10);
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h0C;
    bus.dma_wdata = 32'hDEAD_BEEF; bus.dma_type = dm_word;
    @(negedge clk);
    checks++;
    if (bus.dma_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midrst_gnt got=%b exp=1", bus.dma_gnt);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    bus.dma_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dm_we !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_dm_we we=%b rv=%b exp 0 0", bus.dm_we, bus.dma_rvalid);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    checks++;
    if (mem[3] !== 32'hA000_0003) begin
      failures++;
      $display("FAIL midrst_mem got=%h exp=a0000003", mem[3]);
    end
    clear_inputs();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0C;
    @(negedge clk);
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.dm_we !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after gnt=%b dm_we=%b exp 1 0", bus.cpu_gnt, bus.dm_we);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hA000_0003) begin
      failures++;
      $display("FAIL midrst_readback rv=%b rdata=%h exp 1 a0000003", bus.cpu_rvalid, bus.cpu_rdata);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_tie();
    test_raw();
    test_byte_store();
    test_lock_starvation();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
